// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the sample-rate sequencer (control_muestreo) and the
// derivative datapath top that sits next to it.
//   - estado_t     : sequencer FSM states
//   - W_DEF        : default sample/result width (must match the datapath)
//   - DIV_DEF      : default CLK cycles per sample period
//   - CALC_LAT_DEF : default cycles from y update to a valid datapath result
//   - TO_CYC_DEF   : default ADC timeout (used only with ADC_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package control_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADC_REQ  = 3'd1,
    ADC_WAIT = 3'd2,
    CALC     = 3'd3,
    DAC_WAIT = 3'd4
  } estado_t;

  localparam int W_DEF        = 12;
  localparam int DIV_DEF      = 10000;
  localparam int CALC_LAT_DEF = 2;
  localparam int TO_CYC_DEF   = 255;

endpackage

// File: rtl/generador_tick.sv
// -----------------------------------------------------------------------------
// generador_tick
// Sample-period divider. Counts 0..DIV-1 while run_i is high and emits a
// one-cycle tick_o in the cycle the count sits at DIV-1; the count then wraps.
// With run_i low the count is held at 0 and no tick is produced.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   run_i  : counting enable
//   tick_o : one-cycle sample tick
// -----------------------------------------------------------------------------
module generador_tick
  import control_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_end;

  assign at_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && at_end;

endmodule

// File: rtl/control_muestreo.sv
// -----------------------------------------------------------------------------
// control_muestreo
// Sample-rate sequencer for the derivative datapath and its ADC/DAC endpoints.
// Per sample tick: request an ADC conversion, hold the sample on y, wait
// CALC_LAT cycles for the datapath result, capture it into dac_data while
// pulsing dp_enable (history register advances once), then strobe dac_load
// as soon as the DAC is free.
//
// Optional feature (macro ADC_TIMEOUT_EN): abort ADC_WAIT after TO_CYC cycles
// without adc_done, raising sticky timeout_err. Without the macro ADC_WAIT
// waits indefinitely and timeout_err is tied low.
//
// Ports:
//   CLK, Reset         : clock, synchronous active-high reset
//   run                : sampling allowed
//   adc_start/adc_done : ADC handshake, adc_data valid with adc_done
//   y                  : held sample into the datapath
//   result             : datapath output
//   dp_enable          : one-cycle history-register enable
//   dac_data/dac_load  : captured result and one-cycle DAC write strobe
//   dac_busy           : DAC cannot accept a load
//   busy               : FSM not in IDLE
//   overrun            : sticky, a tick was dropped (cleared by run=0)
//   timeout_err        : sticky ADC timeout
// -----------------------------------------------------------------------------
module control_muestreo
  import control_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int DIV      = DIV_DEF,
  parameter int CALC_LAT = CALC_LAT_DEF,
  parameter int TO_CYC   = TO_CYC_DEF
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         run,
  output logic         adc_start,
  input  logic         adc_done,
  input  logic [W-1:0] adc_data,
  output logic [W-1:0] y,
  input  logic [W-1:0] result,
  output logic         dp_enable,
  output logic [W-1:0] dac_data,
  output logic         dac_load,
  input  logic         dac_busy,
  output logic         busy,
  output logic         overrun,
  output logic         timeout_err
);

  localparam int CCW = $clog2(CALC_LAT + 1);

  if (DIV < 2 || CALC_LAT < 1 || TO_CYC < 1) begin : g_param_err
    $error("control_muestreo: DIV >= 2, CALC_LAT >= 1 and TO_CYC >= 1 required");
  end

  estado_t        estado_q;
  logic           adc_start_q;
  logic           dp_enable_q;
  logic           overrun_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   dac_data_q;
  logic [CCW-1:0] calc_cnt_q;
  logic           tick;

`ifdef ADC_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYC + 1);
  logic [TCW-1:0] to_cnt_q;
  logic           timeout_q;
`endif

  generador_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_i  (CLK),
    .rst_i  (Reset),
    .run_i  (run),
    .tick_o (tick)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado_q    <= IDLE;
      adc_start_q <= 1'b0;
      dp_enable_q <= 1'b0;
      overrun_q   <= 1'b0;
      y_q         <= '0;
      dac_data_q  <= '0;
      calc_cnt_q  <= '0;
`ifdef ADC_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      adc_start_q <= 1'b0;
      dp_enable_q <= 1'b0;

      // Any tick the FSM cannot take (including during the dac_load cycle) is lost.
      if (!run) begin
        overrun_q <= 1'b0;
      end else if (tick && (estado_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      unique case (estado_q)
        IDLE: begin
          if (tick) begin
            estado_q    <= ADC_REQ;
            adc_start_q <= 1'b1;
          end
        end
        ADC_REQ: begin
          estado_q <= ADC_WAIT;
`ifdef ADC_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        ADC_WAIT: begin
          // adc_done takes priority over a timeout expiring in the same cycle.
          if (adc_done) begin
            y_q         <= adc_data;
            calc_cnt_q  <= '0;
            dp_enable_q <= (CALC_LAT == 1);
            estado_q    <= CALC;
          end
`ifdef ADC_TIMEOUT_EN
          else if (to_cnt_q == TCW'(TO_CYC - 1)) begin
            timeout_q <= 1'b1;
            estado_q  <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        CALC: begin
          // dp_enable is registered, so it is raised on entry to the last
          // CALC cycle; the capture edge is the same edge that advances the
          // history register, so dac_data holds y(n)-y(n-1) based result.
          if (calc_cnt_q == CCW'(CALC_LAT - 1)) begin
            dac_data_q <= result;
            estado_q   <= DAC_WAIT;
          end else begin
            calc_cnt_q  <= calc_cnt_q + 1'b1;
            dp_enable_q <= ((int'(calc_cnt_q) + 2) == CALC_LAT);
          end
        end
        DAC_WAIT: begin
          if (!dac_busy) begin
            estado_q <= IDLE;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  // dac_load follows dac_busy within the same cycle so the load lands exactly
  // one cycle after dp_enable when the DAC is free.
  assign dac_load  = (estado_q == DAC_WAIT) && !dac_busy;
  assign adc_start = adc_start_q;
  assign dp_enable = dp_enable_q;
  assign y         = y_q;
  assign dac_data  = dac_data_q;
  assign busy      = (estado_q != IDLE);
  assign overrun   = overrun_q;

`ifdef ADC_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_control_muestreo.sv
// -----------------------------------------------------------------------------
// tb_control_muestreo
// Scoreboard bench for control_muestreo (W=12, DIV=10, CALC_LAT=2, TO_CYC=5).
// A behavioural ADC answers 3 cycles after adc_start with the next queued
// sample; a small derivative datapath (history register, subtract, x150,
// 12-bit truncation) drives result. Each issued sample pushes its expected
// y and dac_data; the monitor pops on dac_load.
// -----------------------------------------------------------------------------
module tb_control_muestreo;

  localparam int W   = 12;
  localparam int DIV = 10;

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] dac;
    bit           lat;
  } exp_t;

  logic         CLK;
  logic         Reset;
  logic         run;
  logic         adc_start;
  logic         adc_done;
  logic [W-1:0] adc_data;
  logic [W-1:0] y;
  logic [W-1:0] result;
  logic         dp_enable;
  logic [W-1:0] dac_data;
  logic         dac_load;
  logic         dac_busy;
  logic         busy;
  logic         overrun;
  logic         timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_done = 0;
  int t_en = 0;
  int t_start = -1;
  int chk_period = 0;
  int n_start = 0;
  int n_load = 0;
  int ns0, nl0;

  exp_t         sb[$];
  logic [W-1:0] adc_q[$];
  exp_t         e_mon;

  control_muestreo #(
    .W(W), .DIV(DIV), .CALC_LAT(2), .TO_CYC(5)
  ) dut (
    .CLK(CLK), .Reset(Reset), .run(run),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .y(y), .result(result), .dp_enable(dp_enable),
    .dac_data(dac_data), .dac_load(dac_load), .dac_busy(dac_busy),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Derivative datapath model: dk = (y - history) * 150, truncated to W bits.
  logic [W-1:0] hist;
  logic [31:0]  prod;
  always @(posedge CLK) begin
    if (Reset) hist <= '0;
    else if (dp_enable) hist <= y;
  end
  assign prod   = {20'd0, W'(y - hist)} * 32'd150;
  assign result = prod[W-1:0];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  // ADC model: responds 3 cycles after adc_start if a sample is queued.
  initial begin
    logic [W-1:0] v;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (adc_start && !Reset && adc_q.size() > 0) begin
        v = adc_q.pop_front();
        repeat (3) @(posedge CLK);
        #1;
        adc_done = 1'b1;
        adc_data = v;
        @(posedge CLK);
        #1;
        adc_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard checker.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (adc_done) t_done = cyc;
      if (adc_start) begin
        n_start++;
        if (chk_period != 0 && t_start >= 0) check("start_period", cyc - t_start, DIV);
        t_start = cyc;
      end
      if (dp_enable) begin
        if (sb.size() == 0) check("dp_enable_unexpected", dp_enable, 0);
        else begin
          check("y_at_enable", y, sb[0].y);
          check("lat_done_to_enable", cyc - t_done, 2);
        end
        t_en = cyc;
      end
      if (dac_load) begin
        n_load++;
        if (sb.size() == 0) check("dac_load_unexpected", dac_load, 0);
        else begin
          e_mon = sb.pop_front();
          check("dac_data", dac_data, e_mon.dac);
          if (e_mon.lat) check("lat_enable_to_load", cyc - t_en, 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    run = 1'b0;
    dac_busy = 1'b0;
    step(3);
    Reset = 1'b0;

    // Reset state
    check("rst_y", y, 0);
    check("rst_dac_data", dac_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_adc_start", adc_start, 0);
    check("rst_dp_enable", dp_enable, 0);
    check("rst_dac_load", dac_load, 0);
    check("rst_timeout", timeout_err, 0);
    step(1);

    // Two samples: 0x100*150 -> 0x600, then 5*150 -> 0x2EE
    adc_q.push_back(12'h100);
    sb.push_back(exp_t'{12'h100, 12'h600, 1'b1});
    adc_q.push_back(12'h105);
    sb.push_back(exp_t'{12'h105, 12'h2EE, 1'b1});
    t_start = -1;
    chk_period = 1;
    run = 1'b1;
    wait_sb_empty("t1_two_samples", 60);
    run = 1'b0;
    chk_period = 0;
    ns0 = n_start;
    step(15);
    check("hold_y", y, 12'h105);
    check("hold_dac_data", dac_data, 12'h2EE);
    check("idle_busy", busy, 0);
    check("no_start_run0", n_start - ns0, 0);

    // DAC busy: tick dropped, overrun, load when busy falls, run=0 clears
    adc_q.push_back(12'h114);
    sb.push_back(exp_t'{12'h114, 12'h8CA, 1'b0});
    dac_busy = 1'b1;
    run = 1'b1;
    step(15);
    check("ovr_before_drop", overrun, 0);
    check("busy_calc", busy, 1);
    step(5);
    check("ovr_after_drop", overrun, 1);
    check("load_held_busy", dac_load, 0);
    check("busy_dac_wait", busy, 1);
    dac_busy = 1'b0;
    step(1);
    check("idle_after_load", busy, 0);
    check("ovr_sticky", overrun, 1);
    check("t3_sb_drained", sb.size(), 0);
    run = 1'b0;
    step(1);
    check("ovr_cleared_run0", overrun, 0);
    step(5);

    // Reset in the middle of CALC
    adc_q.push_back(12'h200);
    run = 1'b1;
    step(14);
    check("calc_y", y, 12'h200);
    check("calc_busy", busy, 1);
    Reset = 1'b1;
    run = 1'b0;
    step(1);
    Reset = 1'b0;
    check("mid_rst_y", y, 0);
    check("mid_rst_dac_data", dac_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dp_enable", dp_enable, 0);
    check("mid_rst_dac_load", dac_load, 0);
    step(5);

    // run falls during ADC_WAIT: one full sequence, no further adc_start
    ns0 = n_start;
    nl0 = n_load;
    adc_q.push_back(12'h050);
    sb.push_back(exp_t'{12'h050, 12'hEE0, 1'b1});
    run = 1'b1;
    step(11);
    check("adc_wait_busy", busy, 1);
    run = 1'b0;
    step(30);
    check("t5_one_load", n_load - nl0, 1);
    check("t5_one_start", n_start - ns0, 1);
    check("t5_y", y, 12'h050);

`ifdef ADC_TIMEOUT_EN
    // ADC never answers: timeout after 5 cycles in ADC_WAIT
    check("to_clear_before", timeout_err, 0);
    run = 1'b1;
    step(15);
    check("to_not_yet", timeout_err, 0);
    check("to_wait_busy", busy, 1);
    step(1);
    check("to_raised", timeout_err, 1);
    check("to_idle", busy, 0);
    check("to_y_kept", y, 12'h050);
    step(4);
    check("to_restart", adc_start, 1);
    run = 1'b0;
    step(10);
    check("to_sticky", timeout_err, 1);
`else
    check("timeout_tied_low", timeout_err, 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
